// File: rtl/dmem_responder.sv
// Word-addressed data memory responder: internal RAM plus a 16-byte MMIO window
// (GPIO, free-running cycle counter, sticky W1C error status), 1-cycle read latency.
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] MMIO_BASE   = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_data_r_en,
    input  logic [31:0] mem_data_r_addr,
    output logic [31:0] mem_data_r_data,
    input  logic        mem_data_w_en,
    input  logic [31:0] mem_data_w_addr,
    input  logic [31:0] mem_data_w_data,
    output logic [31:0] gpio_out,
    output logic        err_oob,
    output logic        err_misaligned
);
    localparam int unsigned AW        = $clog2(DEPTH_WORDS);
    localparam logic [31:0] RAM_BYTES = 32'(4 * DEPTH_WORDS);

    typedef enum logic [1:0] {
        REG_GPIO   = 2'd0,
        REG_CYCLE  = 2'd1,
        REG_STATUS = 2'd2,
        REG_RSVD   = 2'd3
    } mmio_reg_e;

    logic [31:0] mem [DEPTH_WORDS];
    logic [31:0] cycle;
    logic [31:0] cycle_next;
    logic [31:0] mmio_rdata;

    logic        r_ram, r_mmio, r_oob, r_mis;
    logic        w_ram, w_mmio, w_oob, w_mis;
    logic [AW-1:0] r_idx, w_idx;
    mmio_reg_e   r_reg, w_reg;
    logic        set_oob, set_mis, clr_oob, clr_mis;

    // Region decode; RAM takes precedence should the windows ever overlap.
    always_comb begin
        r_ram  = mem_data_r_addr < RAM_BYTES;
        r_mmio = !r_ram && (mem_data_r_addr[31:4] == MMIO_BASE[31:4]);
        r_oob  = !r_ram && !r_mmio;
        r_mis  = mem_data_r_addr[1:0] != 2'b00;
        w_ram  = mem_data_w_addr < RAM_BYTES;
        w_mmio = !w_ram && (mem_data_w_addr[31:4] == MMIO_BASE[31:4]);
        w_oob  = !w_ram && !w_mmio;
        w_mis  = mem_data_w_addr[1:0] != 2'b00;
        r_idx  = mem_data_r_addr[AW+1:2];
        w_idx  = mem_data_w_addr[AW+1:2];
        r_reg  = mmio_reg_e'(mem_data_r_addr[3:2]);
        w_reg  = mmio_reg_e'(mem_data_w_addr[3:2]);
    end

    always_comb begin
        set_oob = (mem_data_r_en && r_oob) || (mem_data_w_en && w_oob);
        set_mis = (mem_data_r_en && r_mis) || (mem_data_w_en && w_mis);
        clr_oob = mem_data_w_en && w_mmio && (w_reg == REG_STATUS) && mem_data_w_data[0];
        clr_mis = mem_data_w_en && w_mmio && (w_reg == REG_STATUS) && mem_data_w_data[1];
    end

    always_comb begin
        mmio_rdata = 32'd0;
        case (r_reg)
            REG_GPIO:   mmio_rdata = gpio_out;
            REG_CYCLE:  mmio_rdata = cycle;
            REG_STATUS: mmio_rdata = {30'd0, err_misaligned, err_oob};
            default:    mmio_rdata = 32'd0;
        endcase
    end

    assign cycle_next = cycle + 32'd1;

    // RAM has no reset so its contents survive it; a write in a reset cycle is dropped.
    always_ff @(posedge clk) begin
        if (!rst && mem_data_w_en && w_ram)
            mem[w_idx] <= mem_data_w_data;
    end

    // Nonblocking read of mem gives read-first behaviour on same-word collisions.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_data_r_data <= 32'd0;
        end else if (mem_data_r_en) begin
            if (r_ram)
                mem_data_r_data <= mem[r_idx];
            else if (r_mmio)
                mem_data_r_data <= mmio_rdata;
            else
                mem_data_r_data <= 32'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gpio_out       <= 32'd0;
            cycle          <= 32'd0;
            err_oob        <= 1'b0;
            err_misaligned <= 1'b0;
        end else begin
            cycle          <= cycle_next;
            err_oob        <= set_oob | (err_oob & ~clr_oob);
            err_misaligned <= set_mis | (err_misaligned & ~clr_mis);
            if (mem_data_w_en && w_mmio && (w_reg == REG_GPIO))
                gpio_out <= mem_data_w_data;
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: RAM, MMIO registers, error flags,
// counter wrap and reset-in-flight behaviour.
module tb_dmem_responder;
    localparam int unsigned DEPTH = 1024;
    localparam logic [31:0] MB    = 32'h8000_0000;
    localparam logic [31:0] OOB_A = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        rst;
    logic        r_en, w_en;
    logic [31:0] r_addr, w_addr, w_data;
    logic [31:0] r_data, gpio;
    logic        e_oob, e_mis;

    int checks   = 0;
    int failures = 0;

    dmem_responder #(.DEPTH_WORDS(DEPTH), .MMIO_BASE(MB)) dut (
        .clk            (clk),
        .rst            (rst),
        .mem_data_r_en  (r_en),
        .mem_data_r_addr(r_addr),
        .mem_data_r_data(r_data),
        .mem_data_w_en  (w_en),
        .mem_data_w_addr(w_addr),
        .mem_data_w_data(w_data),
        .gpio_out       (gpio),
        .err_oob        (e_oob),
        .err_misaligned (e_mis)
    );

    always #5 clk = ~clk;

    // Called at a negedge; drives one cycle of strobes and returns at the next negedge.
    task automatic strobe(input logic re, input logic [31:0] ra,
                          input logic we, input logic [31:0] wa, input logic [31:0] wd);
        r_en = re; r_addr = ra; w_en = we; w_addr = wa; w_data = wd;
        @(posedge clk);
        #1;
        r_en = 1'b0; w_en = 1'b0;
        @(negedge clk);
    endtask

    task automatic rd(input logic [31:0] a);
        strobe(1'b1, a, 1'b0, 32'd0, 32'd0);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        strobe(1'b0, 32'd0, 1'b1, a, d);
    endtask

    task automatic test_reset;
        logic [31:0] c0;
        rst = 1'b1; r_en = 1'b0; w_en = 1'b0;
        r_addr = '0; w_addr = '0; w_data = '0;
        repeat (3) @(negedge clk);
        if (r_data !== 32'd0) begin $display("FAIL reset_rdata got=%h exp=%h", r_data, 32'd0); failures++; end
        checks++;
        if (gpio !== 32'd0) begin $display("FAIL reset_gpio got=%h exp=%h", gpio, 32'd0); failures++; end
        checks++;
        if ({e_mis, e_oob} !== 2'b00) begin $display("FAIL reset_flags got=%b exp=00", {e_mis, e_oob}); failures++; end
        checks++;
        rst = 1'b0;
        rd(MB + 32'h4);
        c0 = r_data;
        if (c0 !== 32'd0) begin $display("FAIL reset_cycle0 got=%h exp=%h", c0, 32'd0); failures++; end
        checks++;
        rd(MB + 32'h4);
        if (r_data !== 32'd1) begin $display("FAIL reset_cycle1 got=%h exp=%h", r_data, 32'd1); failures++; end
        checks++;
    endtask

    task automatic test_ram;
        wr(32'h14, 32'h0);
        wr(32'h10, 32'hDEAD_BEEF);
        rd(32'h10);
        if (r_data !== 32'hDEAD_BEEF) begin $display("FAIL ram_rd10 got=%h exp=%h", r_data, 32'hDEAD_BEEF); failures++; end
        checks++;
        rd(32'h14);
        if (r_data !== 32'h0) begin $display("FAIL ram_rd14 got=%h exp=%h", r_data, 32'h0); failures++; end
        checks++;
        // r_data holds across idle cycles
        wr(32'h40, 32'h1234_5678);
        rd(32'h40);
        repeat (3) @(negedge clk);
        if (r_data !== 32'h1234_5678) begin $display("FAIL ram_hold got=%h exp=%h", r_data, 32'h1234_5678); failures++; end
        checks++;
        if ({e_mis, e_oob} !== 2'b00) begin $display("FAIL ram_noflags got=%b exp=00", {e_mis, e_oob}); failures++; end
        checks++;
    endtask

    task automatic test_same_word;
        wr(32'h20, 32'h1111_1111);
        strobe(1'b1, 32'h20, 1'b1, 32'h20, 32'h2222_2222);
        if (r_data !== 32'h1111_1111) begin $display("FAIL rw_old got=%h exp=%h", r_data, 32'h1111_1111); failures++; end
        checks++;
        rd(32'h20);
        if (r_data !== 32'h2222_2222) begin $display("FAIL rw_new got=%h exp=%h", r_data, 32'h2222_2222); failures++; end
        checks++;
    endtask

    task automatic test_errors;
        rd(OOB_A);
        if (r_data !== 32'h0) begin $display("FAIL oob_rdata got=%h exp=%h", r_data, 32'h0); failures++; end
        checks++;
        if (e_oob !== 1'b1) begin $display("FAIL oob_flag got=%b exp=1", e_oob); failures++; end
        checks++;
        if (e_mis !== 1'b0) begin $display("FAIL oob_nomis got=%b exp=0", e_mis); failures++; end
        checks++;
        // OOB write must not alias onto word 0
        wr(32'h0, 32'h0000_AAAA);
        wr(OOB_A, 32'h0000_BBBB);
        rd(32'h0);
        if (r_data !== 32'h0000_AAAA) begin $display("FAIL oob_wdrop got=%h exp=%h", r_data, 32'h0000_AAAA); failures++; end
        checks++;
        wr(32'h13, 32'h1313_1313);
        if (e_mis !== 1'b1) begin $display("FAIL mis_flag got=%b exp=1", e_mis); failures++; end
        checks++;
        rd(32'h10);
        if (r_data !== 32'h1313_1313) begin $display("FAIL mis_wdata got=%h exp=%h", r_data, 32'h1313_1313); failures++; end
        checks++;
        rd(MB + 32'h8);
        if (r_data !== 32'h3) begin $display("FAIL status_rd got=%h exp=%h", r_data, 32'h3); failures++; end
        checks++;
        wr(MB + 32'h8, 32'h3);
        if ({e_mis, e_oob} !== 2'b00) begin $display("FAIL w1c_clear got=%b exp=00", {e_mis, e_oob}); failures++; end
        checks++;
        rd(OOB_A);
        strobe(1'b1, OOB_A, 1'b1, MB + 32'h8, 32'h1);
        if (e_oob !== 1'b1) begin $display("FAIL set_wins got=%b exp=1", e_oob); failures++; end
        checks++;
        rd(MB + 32'h8);
        if (r_data !== 32'h1) begin $display("FAIL status_oob got=%h exp=%h", r_data, 32'h1); failures++; end
        checks++;
        // clear only bit1 leaves oob set
        wr(MB + 32'h8, 32'h2);
        if ({e_mis, e_oob} !== 2'b01) begin $display("FAIL w1c_bit1 got=%b exp=01", {e_mis, e_oob}); failures++; end
        checks++;
        wr(MB + 32'h8, 32'h1);
    endtask

    task automatic test_mmio;
        logic [31:0] c0;
        wr(MB, 32'hA5A5_0001);
        if (gpio !== 32'hA5A5_0001) begin $display("FAIL gpio_out got=%h exp=%h", gpio, 32'hA5A5_0001); failures++; end
        checks++;
        rd(MB);
        if (r_data !== 32'hA5A5_0001) begin $display("FAIL gpio_rd got=%h exp=%h", r_data, 32'hA5A5_0001); failures++; end
        checks++;
        rd(MB + 32'hC);
        if (r_data !== 32'h0) begin $display("FAIL rsvd_rd got=%h exp=%h", r_data, 32'h0); failures++; end
        checks++;
        rd(MB + 32'h4);
        c0 = r_data;
        repeat (9) @(negedge clk);
        rd(MB + 32'h4);
        if (r_data - c0 !== 32'd10) begin $display("FAIL cycle_delta got=%0d exp=%0d", r_data - c0, 10); failures++; end
        checks++;
        rd(MB + 32'h4);
        c0 = r_data;
        wr(MB + 32'h4, 32'h0);
        rd(MB + 32'h4);
        if (r_data !== c0 + 32'd2) begin $display("FAIL cycle_wr_ign got=%h exp=%h", r_data, c0 + 32'd2); failures++; end
        checks++;
        if ({e_mis, e_oob} !== 2'b00) begin $display("FAIL cycle_wr_noflag got=%b exp=00", {e_mis, e_oob}); failures++; end
        checks++;
    endtask

    task automatic test_wrap;
        force dut.cycle_next = 32'hFFFF_FFFE;
        @(posedge clk);
        #1;
        release dut.cycle_next;
        @(negedge clk);
        rd(MB + 32'h4);
        if (r_data !== 32'hFFFF_FFFE) begin $display("FAIL wrap0 got=%h exp=%h", r_data, 32'hFFFF_FFFE); failures++; end
        checks++;
        rd(MB + 32'h4);
        if (r_data !== 32'hFFFF_FFFF) begin $display("FAIL wrap1 got=%h exp=%h", r_data, 32'hFFFF_FFFF); failures++; end
        checks++;
        rd(MB + 32'h4);
        if (r_data !== 32'h0) begin $display("FAIL wrap2 got=%h exp=%h", r_data, 32'h0); failures++; end
        checks++;
    endtask

    task automatic test_reset_mid;
        wr(32'h10, 32'hDEAD_BEEF);
        wr(32'h18, 32'h0000_0077);
        rd(OOB_A);
        wr(32'h1, 32'h0);
        rst = 1'b1;
        strobe(1'b1, 32'h10, 1'b1, 32'h18, 32'h0000_0055);
        rst = 1'b0;
        if (r_data !== 32'h0) begin $display("FAIL rstmid_rdata got=%h exp=%h", r_data, 32'h0); failures++; end
        checks++;
        if (gpio !== 32'h0) begin $display("FAIL rstmid_gpio got=%h exp=%h", gpio, 32'h0); failures++; end
        checks++;
        if ({e_mis, e_oob} !== 2'b00) begin $display("FAIL rstmid_flags got=%b exp=00", {e_mis, e_oob}); failures++; end
        checks++;
        rd(MB + 32'h4);
        if (r_data !== 32'h0) begin $display("FAIL rstmid_cycle got=%h exp=%h", r_data, 32'h0); failures++; end
        checks++;
        rd(32'h10);
        if (r_data !== 32'hDEAD_BEEF) begin $display("FAIL rstmid_retain got=%h exp=%h", r_data, 32'hDEAD_BEEF); failures++; end
        checks++;
        rd(32'h18);
        if (r_data !== 32'h0000_0077) begin $display("FAIL rstmid_nowrite got=%h exp=%h", r_data, 32'h0000_0077); failures++; end
        checks++;
    endtask

    initial begin
        test_reset;
        test_ram;
        test_same_word;
        test_errors;
        test_mmio;
        test_wrap;
        test_reset_mid;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
